mac_accumulator: RTL and testbench

Accumulation stage of the MAC unit: accepts a stream of signed operand pairs, multiplies each pair and sums LEN consecutive products into a saturating accumulator. Each completed sum is presented as one result word on a valid/ready output port. It sits directly downstream of the operand latches, consuming their held operands, and feeds the result consumer (output register or bus interface).

---
 rtl/mac_accumulator_if.sv | 26 ++
 rtl/mac_accumulator.sv | 159 +++++++++++++++
 tb/tb_mac_accumulator.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mac_accumulator_if.sv
// Operand/result bus of the MAC accumulation stage.
// The master side is the environment (operand source plus result consumer);
// the slave side is the accumulator itself.
interface mac_accumulator_if #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 20
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  a;
  logic signed [IN_W-1:0]  b;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;
  logic                    out_sat;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/mac_accumulator.sv
// MAC accumulation stage: multiplies each accepted signed operand pair and
// sums LEN consecutive products into a saturating accumulator. Each finished
// sum, with a sticky "saturated somewhere in this vector" flag, is held in a
// one-word output slot until the consumer takes it.
module mac_accumulator #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 20,
  parameter int LEN   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  mac_accumulator_if.slave bus
);

  localparam int PROD_W = 2 * IN_W;
  localparam int CNT_W  = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_e;

  // Saturating add. Returns {overflow, clamped_sum}; overflow is taken from
  // a one-bit-wider sum, where disagreement of the top two bits means the
  // true result does not fit in ACC_W bits.
  function automatic logic [ACC_W:0] sat_add(
    input logic signed [ACC_W-1:0] x,
    input logic signed [ACC_W-1:0] y
  );
    logic signed [ACC_W:0]   s;
    logic                    ovf;
    logic signed [ACC_W-1:0] r;
    s   = {x[ACC_W-1], x} + {y[ACC_W-1], y};
    ovf = s[ACC_W] ^ s[ACC_W-1];
    if (!ovf) begin
      r = s[ACC_W-1:0];
    end else if (s[ACC_W]) begin
      r = ACC_MIN;
    end else begin
      r = ACC_MAX;
    end
    return {ovf, r};
  endfunction

  // State
  slot_e                   slot_q, slot_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    sat_q, sat_d;
  logic signed [ACC_W-1:0] out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;

  // Datapath intermediates
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  p_ext;
  logic [ACC_W:0]           sum_res;
  logic signed [ACC_W-1:0]  acc_new;
  logic                     sat_new;

  // Handshake intermediates
  logic last_elem;
  logic accept;
  logic final_acc;

  assign prod  = bus.a * bus.b;
  assign p_ext = ACC_W'(prod);

  // The last element of a vector is the only one that can be stalled: it
  // needs the output slot, which is unavailable only while a word is held
  // and the consumer is not taking it this same cycle.
  assign last_elem    = (cnt_q == LAST);
  assign bus.in_ready = !clr && !(last_elem && (slot_q == FULL) && !bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign final_acc    = accept && last_elem;

  // Accumulator value and sticky flag that an accept this cycle would produce;
  // the first element of a vector restarts the sum instead of adding to it.
  always_comb begin
    sum_res = sat_add(acc_q, p_ext);
    acc_new = p_ext;
    sat_new = 1'b0;
    if (cnt_q != '0) begin
      acc_new = sum_res[ACC_W-1:0];
      sat_new = sat_q | sum_res[ACC_W];
    end
  end

  // Element counter and running sum: clr abandons the partial vector,
  // otherwise each accept advances the count and folds in the product.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    sat_d = sat_q;
    if (clr) begin
      cnt_d = '0;
      acc_d = '0;
      sat_d = 1'b0;
    end else if (accept) begin
      cnt_d = last_elem ? '0 : cnt_q + 1'b1;
      acc_d = acc_new;
      sat_d = sat_new;
    end
  end

  // Output slot FSM: a final accept always (re)fills the slot, which is why
  // a take plus a simultaneous final accept leaves it FULL with the new word.
  always_comb begin
    slot_d     = slot_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    case (slot_q)
      EMPTY: begin
        if (final_acc) begin
          slot_d     = FULL;
          out_data_d = acc_new;
          out_sat_d  = sat_new;
        end
      end
      FULL: begin
        if (final_acc) begin
          slot_d     = FULL;
          out_data_d = acc_new;
          out_sat_d  = sat_new;
        end else if (bus.out_ready) begin
          slot_d = EMPTY;
        end
      end
      default: slot_d = EMPTY;
    endcase
  end

  // Register update; reset drops both the partial sum and any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q     <= EMPTY;
      cnt_q      <= '0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign bus.out_valid = (slot_q == FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: a default-width instance (ACC_W=20)
// and a narrow instance (ACC_W=16) used for the saturation vectors.
module tb_mac_accumulator;

  logic clk;
  logic rst_n;
  logic clr0;
  logic clr1;

  int checks = 0;
  int errors = 0;

  mac_accumulator_if #(.IN_W(8), .ACC_W(20)) bus0 ();
  mac_accumulator_if #(.IN_W(8), .ACC_W(16)) bus1 ();

  mac_accumulator #(.IN_W(8), .ACC_W(20), .LEN(4)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr0),
    .bus   (bus0)
  );

  mac_accumulator #(.IN_W(8), .ACC_W(16), .LEN(4)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr1),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input int x, input int y);
    bus0.in_valid = v;
    bus0.a        = 8'(x);
    bus0.b        = 8'(y);
  endtask

  task automatic drv1(input logic v, input int x, input int y);
    bus1.in_valid = v;
    bus1.a        = 8'(x);
    bus1.b        = 8'(y);
  endtask

  task automatic send0(input int x, input int y);
    drv0(1'b1, x, y);
    tick();
  endtask

  task automatic send1(input int x, input int y);
    drv1(1'b1, x, y);
    tick();
  endtask

  function automatic logic [31:0] d0();
    return {12'b0, bus0.out_data};
  endfunction

  function automatic logic [31:0] d1();
    return {16'b0, bus1.out_data};
  endfunction

  initial begin
    rst_n = 1'b0;
    clr0  = 1'b0;
    clr1  = 1'b0;
    drv0(1'b0, 0, 0);
    drv1(1'b0, 0, 0);
    bus0.out_ready = 1'b1;
    bus1.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    chk("rst_out_data", d0(), 32'd0);
    chk("rst_out_sat", 32'(bus0.out_sat), 32'd0);
    chk("rst_out_valid_n", 32'(bus1.out_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus0.in_ready), 32'd1);
    tick();

    // Unsigned-looking sum: 2+4+6+8 = 20
    for (int i = 1; i <= 4; i++) begin
      drv0(1'b1, i, 2);
      #1;
      chk("t1_in_ready", 32'(bus0.in_ready), 32'd1);
      chk("t1_no_early_valid", 32'(bus0.out_valid), 32'd0);
      tick();
    end
    drv0(1'b0, 0, 0);
    chk("t1_out_valid", 32'(bus0.out_valid), 32'd1);
    chk("t1_out_data", d0(), 32'd20);
    chk("t1_out_sat", 32'(bus0.out_sat), 32'd0);
    tick();
    chk("t1_one_cycle", 32'(bus0.out_valid), 32'd0);

    // Signed sum: -15+4+1+0 = -10
    send0(-3, 5);
    send0(2, 2);
    send0(-1, -1);
    send0(0, 7);
    drv0(1'b0, 0, 0);
    chk("t2_out_valid", 32'(bus0.out_valid), 32'd1);
    chk("t2_out_data", d0(), 32'h000FFFF6);
    chk("t2_out_sat", 32'(bus0.out_sat), 32'd0);
    tick();

    // Saturation on the 16-bit instance
    repeat (4) send1(-128, -128);
    drv1(1'b0, 0, 0);
    chk("t3_pos_valid", 32'(bus1.out_valid), 32'd1);
    chk("t3_pos_data", d1(), 32'h7FFF);
    chk("t3_pos_sat", 32'(bus1.out_sat), 32'd1);
    repeat (4) send1(127, -128);
    drv1(1'b0, 0, 0);
    chk("t3_neg_data", d1(), 32'h8000);
    chk("t3_neg_sat", 32'(bus1.out_sat), 32'd1);
    repeat (4) send1(1, 1);
    drv1(1'b0, 0, 0);
    chk("t3_clear_data", d1(), 32'd4);
    chk("t3_clear_sat", 32'(bus1.out_sat), 32'd0);
    tick();

    // Backpressure: word A held, vector B stalls on its last element
    bus0.out_ready = 1'b0;
    repeat (4) send0(1, 1);
    drv0(1'b0, 0, 0);
    chk("t4_a_valid", 32'(bus0.out_valid), 32'd1);
    chk("t4_a_data", d0(), 32'd4);
    for (int i = 0; i < 3; i++) begin
      drv0(1'b1, 2, 1);
      #1;
      chk("t4_b_head_ready", 32'(bus0.in_ready), 32'd1);
      tick();
    end
    drv0(1'b1, 2, 1);
    #1;
    chk("t4_b_last_stall", 32'(bus0.in_ready), 32'd0);
    tick();
    chk("t4_stall_ready", 32'(bus0.in_ready), 32'd0);
    chk("t4_hold_valid", 32'(bus0.out_valid), 32'd1);
    chk("t4_hold_data", d0(), 32'd4);
    bus0.out_ready = 1'b1;
    #1;
    chk("t4_release_ready", 32'(bus0.in_ready), 32'd1);
    tick();
    drv0(1'b0, 0, 0);
    chk("t4_b_valid", 32'(bus0.out_valid), 32'd1);
    chk("t4_b_data", d0(), 32'd8);
    tick();
    chk("t4_drained", 32'(bus0.out_valid), 32'd0);

    // Asynchronous reset mid-vector with a word pending
    bus0.out_ready = 1'b0;
    repeat (4) send0(1, 1);
    send0(5, 5);
    send0(5, 5);
    drv0(1'b0, 0, 0);
    chk("t5_pending", 32'(bus0.out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(bus0.out_valid), 32'd0);
    chk("t5_rst_data", d0(), 32'd0);
    chk("t5_rst_sat", 32'(bus0.out_sat), 32'd0);
    #1;
    rst_n = 1'b1;
    bus0.out_ready = 1'b1;
    #1;
    chk("t5_post_ready", 32'(bus0.in_ready), 32'd1);
    repeat (4) send0(1, 1);
    drv0(1'b0, 0, 0);
    chk("t5_post_valid", 32'(bus0.out_valid), 32'd1);
    chk("t5_post_data", d0(), 32'd4);
    tick();

    // clr on element 2 with a word pending
    bus0.out_ready = 1'b0;
    repeat (4) send0(1, 1);
    send0(3, 3);
    send0(3, 3);
    drv0(1'b1, 3, 3);
    clr0 = 1'b1;
    #1;
    chk("t6_clr_ready", 32'(bus0.in_ready), 32'd0);
    tick();
    clr0 = 1'b0;
    chk("t6_keep_valid", 32'(bus0.out_valid), 32'd1);
    chk("t6_keep_data", d0(), 32'd4);
    bus0.out_ready = 1'b1;
    repeat (3) send0(3, 3);
    chk("t6_no_early", 32'(bus0.out_valid), 32'd0);
    send0(3, 3);
    drv0(1'b0, 0, 0);
    chk("t6_valid", 32'(bus0.out_valid), 32'd1);
    chk("t6_data", d0(), 32'd36);
    chk("t6_sat", 32'(bus0.out_sat), 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
